// File: rtl/data_mem_responder_if.sv
// Core-side MEM-stage request/response signals plus the MMIO req/ack bus
// seen by the data-memory responder.
interface data_mem_responder_if;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_result;
  logic        mem_stall;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic [31:0] io_rdata;
  logic        io_ack;

  modport slave (
    input  mem_mem_read, mem_mem_write, mem_funct3, mem_alu_result, mem_write_data,
    input  io_rdata, io_ack,
    output mem_read_result, mem_stall,
    output io_req, io_we, io_addr, io_wdata, io_be
  );

  modport master (
    output mem_mem_read, mem_mem_write, mem_funct3, mem_alu_result, mem_write_data,
    output io_rdata, io_ack,
    input  mem_read_result, mem_stall,
    input  io_req, io_we, io_addr, io_wdata, io_be
  );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data memory: single-cycle byte-lane RAM below MMIO_BASE, stalling
// req/ack MMIO bus above it. Optional macro MISALIGN_TRAP_EN adds mem_misaligned.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int unsigned IO_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                 mem_misaligned
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IO_WAIT = 2'd1,
    S_IO_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          stall_c, io_req_c;

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [31:0]   rd_word_q;
  logic [2:0]    rd_fn_q;
  logic [1:0]    rd_off_q;

  logic [31:0]   io_addr_q, io_wdata_q;
  logic [3:0]    io_be_q;
  logic          io_we_q, io_load_q;
  logic [2:0]    io_fn_q;
  logic [CW-1:0] cnt_q;

  logic [3:0]    lane_be;
  logic [31:0]   lane_data;
  logic          is_mmio, is_load, idle_req, misaligned, timeout;
  logic          ram_we, ram_rd, mis_load, mmio_start;
  logic [AW-1:0] word_idx;
  logic [7:0]    rd_bytes [4];
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   result_c;

  assign is_mmio  = bus.mem_alu_result >= MMIO_BASE;
  assign is_load  = bus.mem_mem_read & ~bus.mem_mem_write;
  assign idle_req = (state_q == S_IDLE) & (bus.mem_mem_read | bus.mem_mem_write);
  assign word_idx = bus.mem_alu_result[AW+1:2];
  assign timeout  = (cnt_q == CW'(IO_TIMEOUT - 1));

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (bus.mem_funct3[1:0])
      2'b01:   misaligned = bus.mem_alu_result[0];
      2'b10:   misaligned = |bus.mem_alu_result[1:0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // A store with read also high is treated purely as a store.
  assign ram_we     = idle_req & bus.mem_mem_write & ~is_mmio & ~misaligned;
  assign ram_rd     = idle_req & is_load & ~is_mmio & ~misaligned;
  assign mis_load   = idle_req & is_load & misaligned;
  assign mmio_start = idle_req & is_mmio & ~misaligned;

  // Halfword lanes use only a[1], so a stray a[0] lands on the aligned pair.
  always_comb begin
    lane_be   = 4'hF;
    lane_data = bus.mem_write_data;
    case (bus.mem_funct3[1:0])
      2'b00: begin
        lane_be   = 4'b0001 << bus.mem_alu_result[1:0];
        lane_data = {4{bus.mem_write_data[7:0]}};
      end
      2'b01: begin
        lane_be   = 4'b0011 << {bus.mem_alu_result[1], 1'b0};
        lane_data = {2{bus.mem_write_data[15:0]}};
      end
      default: begin
        lane_be   = 4'hF;
        lane_data = bus.mem_write_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) ram_q[word_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    io_req_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mmio_start) begin
          state_d = S_IO_WAIT;
          stall_c = 1'b1;
        end
      end
      S_IO_WAIT: begin
        io_req_c = 1'b1;
        stall_c  = 1'b1;
        if (bus.io_ack || timeout) state_d = S_IO_DONE;
      end
      S_IO_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_word_q  <= '0;
      rd_fn_q    <= '0;
      rd_off_q   <= '0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      io_be_q    <= '0;
      io_we_q    <= 1'b0;
      io_load_q  <= 1'b0;
      io_fn_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (ram_rd) begin
        rd_word_q <= ram_q[word_idx];
        rd_fn_q   <= bus.mem_funct3;
        rd_off_q  <= bus.mem_alu_result[1:0];
      end else if (mis_load) begin
        rd_word_q <= '0;
        rd_fn_q   <= bus.mem_funct3;
        rd_off_q  <= bus.mem_alu_result[1:0];
      end else if ((state_q == S_IO_WAIT) && io_load_q && (bus.io_ack || timeout)) begin
        // Ack wins over a timeout landing in the same cycle.
        rd_word_q <= bus.io_ack ? bus.io_rdata : 32'h0;
        rd_fn_q   <= io_fn_q;
        rd_off_q  <= io_addr_q[1:0];
      end
      if (mmio_start) begin
        io_addr_q  <= bus.mem_alu_result;
        io_wdata_q <= lane_data;
        io_be_q    <= lane_be;
        io_we_q    <= bus.mem_mem_write;
        io_load_q  <= is_load;
        io_fn_q    <= bus.mem_funct3;
        cnt_q      <= '0;
      end else if (state_q == S_IO_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= idle_req & misaligned;
  end
  assign mem_misaligned = mis_q;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_bytes
    assign rd_bytes[gi] = rd_word_q[gi*8 +: 8];
  end

  assign rd_byte = rd_bytes[rd_off_q];
  assign rd_half = rd_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

  always_comb begin
    result_c = rd_word_q;
    case (rd_fn_q)
      3'b000:  result_c = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  result_c = {24'h0, rd_byte};
      3'b001:  result_c = {{16{rd_half[15]}}, rd_half};
      3'b101:  result_c = {16'h0, rd_half};
      default: result_c = rd_word_q;
    endcase
  end

  assign bus.mem_read_result = result_c;
  assign bus.mem_stall       = stall_c;
  assign bus.io_req          = io_req_c;
  assign bus.io_we           = io_req_c & io_we_q;
  assign bus.io_addr         = io_addr_q;
  assign bus.io_wdata        = io_wdata_q;
  assign bus.io_be           = io_be_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: loads push expected results, a
// negedge monitor pops them one cycle after each accepted load.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();
`ifdef MISALIGN_TRAP_EN
  logic mem_misaligned;
`endif

  data_mem_responder #(
    .DEPTH_WORDS(1024),
    .MMIO_BASE  (32'hFFFF_0000),
    .IO_TIMEOUT (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MISALIGN_TRAP_EN
    ,
    .mem_misaligned(mem_misaligned)
`endif
  );

  typedef struct {
    logic [31:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Scoreboard monitor: a load accepted in one cycle is compared in the next.
  logic pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load_result", bus.mem_read_result, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check(e.name, bus.mem_read_result, e.v);
      end
    end
    pend = bus.mem_mem_read & ~bus.mem_mem_write & ~bus.mem_stall & ~rst;
  end

  int stall_cyc = 0;
  int req_cyc   = 0;
  always @(negedge clk) begin
    if (bus.mem_stall) stall_cyc++;
    if (bus.io_req)    req_cyc++;
  end

  // MMIO responder: acks on the ack_on-th io_req cycle (0 = never).
  int          ack_on   = 0;
  logic [31:0] ack_data = 32'h0;
  int          io_cyc   = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;
  initial begin
    bus.io_ack   = 1'b0;
    bus.io_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.io_req) begin
        io_cyc++;
        if (io_cyc == 1) begin
          seen_addr  = bus.io_addr;
          seen_wdata = bus.io_wdata;
          seen_be    = bus.io_be;
          seen_we    = bus.io_we;
        end
        if (io_cyc == ack_on) begin
          bus.io_ack   = 1'b1;
          bus.io_rdata = ack_data;
        end else begin
          bus.io_ack = 1'b0;
        end
      end else begin
        io_cyc     = 0;
        bus.io_ack = 1'b0;
      end
    end
  end

  task automatic drive_idle();
    bus.mem_mem_read   = 1'b0;
    bus.mem_mem_write  = 1'b0;
    bus.mem_funct3     = 3'b000;
    bus.mem_alu_result = 32'h0;
    bus.mem_write_data = 32'h0;
  endtask

  // Presents one request, holds it through any stall, returns just after the
  // edge on which it was accepted.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] expv, input string name);
    exp_t e;
    int   guard;
    bus.mem_mem_read   = rd;
    bus.mem_mem_write  = wr;
    bus.mem_funct3     = f3;
    bus.mem_alu_result = a;
    bus.mem_write_data = d;
    if (rd && !wr) begin
      e.v    = expv;
      e.name = name;
      exp_q.push_back(e);
    end
    $display("txn %s rd=%0b wr=%0b f3=%03b addr=%h wdata=%h exp=%h", name, rd, wr, f3, a, d, expv);
    guard = 0;
    @(negedge clk);
    while (bus.mem_stall && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check({name, "_stall_bound"}, {31'h0, bus.mem_stall}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read_result", bus.mem_read_result, 32'h0);
    check("rst_stall", {31'h0, bus.mem_stall}, 32'h0);
    check("rst_io_req", {31'h0, bus.io_req}, 32'h0);
    check("rst_io_we", {31'h0, bus.io_we}, 32'h0);
    check("rst_io_addr", bus.io_addr, 32'h0);
    check("rst_io_wdata", bus.io_wdata, 32'h0);
    check("rst_io_be", {28'h0, bus.io_be}, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("rst_misaligned", {31'h0, mem_misaligned}, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Store then back-to-back load
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'h1234_5678, 32'h0, "t1_sw");
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_5678, "t1_lw");

    // read & write together: store only, result register untouched
    access(1'b1, 1'b1, 3'b010, 32'h20, 32'h0BAD_F00D, 32'h0, "rw_store");
    drive_idle();
    @(negedge clk);
    check("rw_result_held", bus.mem_read_result, 32'h1234_5678);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BAD_F00D, "rw_lw");

    // Byte store and extensions
    access(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_0080, 32'h0, "t2_sb");
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, "t2_lb");
    access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, "t2_lbu");
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h8034_5678, "t2_lw");

    // Halfword extensions
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'h8001_7FFF, 32'h0, "t3_sw");
    access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8001, "t3_lh_hi");
    access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8001, "t3_lhu_hi");
    access(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'h0000_7FFF, "t3_lh_lo");

`ifdef MISALIGN_TRAP_EN
    access(1'b0, 1'b1, 3'b010, 32'h12, 32'hDEAD_BEEF, 32'h0, "t6_sw_mis");
    drive_idle();
    @(negedge clk);
    check("t6_mis_high", {31'h0, mem_misaligned}, 32'h1);
    @(negedge clk);
    check("t6_mis_low", {31'h0, mem_misaligned}, 32'h0);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h8001_7FFF, "t6_ram_intact");
    access(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, "t6_lw_mis");
    drive_idle();
    @(negedge clk);
    check("t6_lw_mis_flag", {31'h0, mem_misaligned}, 32'h1);
    @(posedge clk);
    #1;
    req_cyc = 0;
    access(1'b0, 1'b1, 3'b001, 32'hFFFF_0013, 32'h1111, 32'h0, "t6_sh_mmio_mis");
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_mmio", req_cyc, 32'd0);
`else
    access(1'b1, 1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFF_8001, "na_lh_odd");
    access(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, 32'h8001_7FFF, "na_lw_odd");
`endif

    // MMIO load, ack on third io_req cycle
    ack_on    = 3;
    ack_data  = 32'hCAFE_F00D;
    stall_cyc = 0;
    req_cyc   = 0;
    access(1'b1, 1'b0, 3'b010, 32'hFFFF_0004, 32'h0, 32'hCAFE_F00D, "t4_lw_mmio");
    drive_idle();
    check("t4_stall_cycles", stall_cyc, 32'd4);
    check("t4_io_req_cycles", req_cyc, 32'd3);
    check("t4_io_addr", seen_addr, 32'hFFFF_0004);
    check("t4_io_be", {28'h0, seen_be}, 32'hF);
    check("t4_io_we", {31'h0, seen_we}, 32'h0);

    // MMIO byte store, ack immediately: minimum 3-cycle cost
    ack_on    = 1;
    stall_cyc = 0;
    req_cyc   = 0;
    access(1'b0, 1'b1, 3'b000, 32'hFFFF_0011, 32'h0000_00A5, 32'h0, "mmio_sb");
    drive_idle();
    check("sb_stall_cycles", stall_cyc, 32'd2);
    check("sb_io_req_cycles", req_cyc, 32'd1);
    check("sb_io_addr", seen_addr, 32'hFFFF_0011);
    check("sb_io_be", {28'h0, seen_be}, 32'h2);
    check("sb_io_wdata", seen_wdata, 32'hA5A5_A5A5);
    check("sb_io_we", {31'h0, seen_we}, 32'h1);

    // MMIO load with no ack: timeout
    ack_on    = 0;
    stall_cyc = 0;
    req_cyc   = 0;
    access(1'b1, 1'b0, 3'b010, 32'hFFFF_0008, 32'h0, 32'h0, "t5_lw_timeout");
    drive_idle();
    check("t5_stall_cycles", stall_cyc, 32'd9);
    check("t5_io_req_cycles", req_cyc, 32'd8);

    // Reset while in IO_WAIT
    $display("txn t5_rst_in_wait addr=ffff0008");
    bus.mem_mem_read   = 1'b1;
    bus.mem_funct3     = 3'b010;
    bus.mem_alu_result = 32'hFFFF_0008;
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wait", {31'h0, bus.io_req}, 32'h1);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    check("t5_rst_io_req", {31'h0, bus.io_req}, 32'h0);
    check("t5_rst_stall", {31'h0, bus.mem_stall}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h8001_7FFF, "t5_ram_intact");

    drive_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
